// File: rtl/controller_sequencer_if.sv
// Control bus between the SAP-1 sequencer and its datapath.
// Carries the opcode in and the control word, halt and ring state out.
interface controller_sequencer_if;
  logic [3:0] opcode;
  logic       cp;
  logic       ep;
  logic       lm_n;
  logic       ce_n;
  logic       li_n;
  logic       ei_n;
  logic       la_n;
  logic       ea;
  logic       su;
  logic       eu;
  logic       lb_n;
  logic       lo_n;
  logic       halt;
  logic [5:0] tstate;

  // The sequencer drives the control word.
  modport master (
    input  opcode,
    output cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n, halt, tstate
  );

  // The datapath supplies the opcode and consumes the control word.
  modport slave (
    output opcode,
    input  cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n, halt, tstate
  );
endinterface

// File: rtl/controller_sequencer.sv
// SAP-1 control unit: six-state ring (T1..T6) plus a terminal HALTED state.
// Controls are a combinational decode of ring state and opcode, forced inactive during reset.
module controller_sequencer #(
  parameter logic [3:0] OP_LDA = 4'h0,
  parameter logic [3:0] OP_ADD = 4'h1,
  parameter logic [3:0] OP_SUB = 4'h2,
  parameter logic [3:0] OP_OUT = 4'hE,
  parameter logic [3:0] OP_HLT = 4'hF
) (
  input  logic                   clk,
  input  logic                   reset,
  controller_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    StT1     = 3'd0,
    StT2     = 3'd1,
    StT3     = 3'd2,
    StT4     = 3'd3,
    StT5     = 3'd4,
    StT6     = 3'd5,
    StHalted = 3'd6
  } state_e;

  state_e state_q, state_d;

  // State register; reset returns the ring to T1 immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StT1;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: advance the ring, divert to HALTED from T4 of HLT.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StT1:     state_d = StT2;
      StT2:     state_d = StT3;
      StT3:     state_d = StT4;
      StT4:     state_d = (bus.opcode == OP_HLT) ? StHalted : StT5;
      StT5:     state_d = StT6;
      StT6:     state_d = StT1;
      StHalted: state_d = StHalted;
      default:  state_d = StT1;
    endcase
  end

  // Control-word decode; every control starts inactive and reset keeps it so.
  always_comb begin
    bus.cp   = 1'b0;
    bus.ep   = 1'b0;
    bus.lm_n = 1'b1;
    bus.ce_n = 1'b1;
    bus.li_n = 1'b1;
    bus.ei_n = 1'b1;
    bus.la_n = 1'b1;
    bus.ea   = 1'b0;
    bus.su   = 1'b0;
    bus.eu   = 1'b0;
    bus.lb_n = 1'b1;
    bus.lo_n = 1'b1;
    bus.halt = 1'b0;
    if (!reset) begin
      unique case (state_q)
        StT1: begin
          bus.ep   = 1'b1;
          bus.lm_n = 1'b0;
        end
        StT2: bus.cp = 1'b1;
        StT3: begin
          bus.ce_n = 1'b0;
          bus.li_n = 1'b0;
        end
        StT4: begin
          if (bus.opcode == OP_LDA || bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
            bus.ei_n = 1'b0;
            bus.lm_n = 1'b0;
          end else if (bus.opcode == OP_OUT) begin
            bus.ea   = 1'b1;
            bus.lo_n = 1'b0;
          end else if (bus.opcode == OP_HLT) begin
            bus.halt = 1'b1;
          end
        end
        StT5: begin
          if (bus.opcode == OP_LDA) begin
            bus.ce_n = 1'b0;
            bus.la_n = 1'b0;
          end else if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
            bus.ce_n = 1'b0;
            bus.lb_n = 1'b0;
          end
        end
        StT6: begin
          if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
            bus.eu   = 1'b1;
            bus.la_n = 1'b0;
            bus.su   = (bus.opcode == OP_SUB);
          end
        end
        StHalted: bus.halt = 1'b1;
        default: ;
      endcase
    end
  end

  // Ring position; HALTED parks the visible ring on T4.
  always_comb begin
    bus.tstate = 6'b000001;
    unique case (state_q)
      StT1:     bus.tstate = 6'b000001;
      StT2:     bus.tstate = 6'b000010;
      StT3:     bus.tstate = 6'b000100;
      StT4:     bus.tstate = 6'b001000;
      StT5:     bus.tstate = 6'b010000;
      StT6:     bus.tstate = 6'b100000;
      StHalted: bus.tstate = 6'b001000;
      default:  bus.tstate = 6'b000001;
    endcase
  end

  // At most one bus driver at a time, and the ring is always one-hot.
  a_one_driver : assert property (@(posedge clk) disable iff (reset)
    $onehot0({bus.ep, ~bus.ce_n, ~bus.ei_n, bus.ea, bus.eu}));
  a_onehot_ring : assert property (@(posedge clk) disable iff (reset) $onehot(bus.tstate));

endmodule

// File: tb/tb_controller_sequencer.sv
// Directed bench for the SAP-1 sequencer: fetch/execute words per opcode, halt, resets.
module tb_controller_sequencer;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  controller_sequencer_if bus ();

  controller_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n, halt}
  logic [12:0] ctl;
  assign ctl = {bus.cp, bus.ep, bus.lm_n, bus.ce_n, bus.li_n, bus.ei_n, bus.la_n,
                bus.ea, bus.su, bus.eu, bus.lb_n, bus.lo_n, bus.halt};

  localparam logic [12:0] CInact  = 13'b0_0_1_1_1_1_1_0_0_0_1_1_0;
  localparam logic [12:0] CT1     = 13'b0_1_0_1_1_1_1_0_0_0_1_1_0;
  localparam logic [12:0] CT2     = 13'b1_0_1_1_1_1_1_0_0_0_1_1_0;
  localparam logic [12:0] CT3     = 13'b0_0_1_0_0_1_1_0_0_0_1_1_0;
  localparam logic [12:0] CMemT4  = 13'b0_0_0_1_1_0_1_0_0_0_1_1_0;
  localparam logic [12:0] CLdaT5  = 13'b0_0_1_0_1_1_0_0_0_0_1_1_0;
  localparam logic [12:0] CAluT5  = 13'b0_0_1_0_1_1_1_0_0_0_0_1_0;
  localparam logic [12:0] CAddT6  = 13'b0_0_1_1_1_1_0_0_0_1_1_1_0;
  localparam logic [12:0] CSubT6  = 13'b0_0_1_1_1_1_0_0_1_1_1_1_0;
  localparam logic [12:0] COutT4  = 13'b0_0_1_1_1_1_1_1_0_0_1_0_0;
  localparam logic [12:0] CHalt   = 13'b0_0_1_1_1_1_1_0_0_0_1_1_1;

  // Move to the middle of the next clock cycle, away from the rising edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [12:0] exp [6];
    logic [5:0]  ts;
    exp = '{CT1, CT2, CT3, CMemT4, CLdaT5, CInact};
    reset = 1'b1;
    bus.opcode = 4'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.tstate !== 6'b000001 || ctl !== CInact) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: tstate=%b ctl=%b, required tstate=000001 ctl=%b",
                 i, bus.tstate, ctl, CInact);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int i = 0; i < 6; i++) begin
      ts = 6'b000001 << i;
      checks++;
      if (bus.tstate !== ts || ctl !== exp[i]) begin
        errors++;
        $display("FAIL lda T%0d: tstate=%b ctl=%b, required tstate=%b ctl=%b",
                 i + 1, bus.tstate, ctl, ts, exp[i]);
      end
      step();
    end
    checks++;
    if (bus.tstate !== 6'b000001 || ctl !== CT1) begin
      errors++;
      $display("FAIL lda_wrap: tstate=%b ctl=%b, required tstate=000001 ctl=%b",
               bus.tstate, ctl, CT1);
    end
  endtask

  task automatic test_add_sub();
    logic [12:0] exp_add [6];
    logic [12:0] exp_sub [6];
    logic [5:0]  ts;
    exp_add = '{CT1, CT2, CT3, CMemT4, CAluT5, CAddT6};
    exp_sub = '{CT1, CT2, CT3, CMemT4, CAluT5, CSubT6};
    bus.opcode = 4'h1;
    for (int i = 0; i < 6; i++) begin
      ts = 6'b000001 << i;
      checks++;
      if (bus.tstate !== ts || ctl !== exp_add[i]) begin
        errors++;
        $display("FAIL add T%0d: tstate=%b ctl=%b, required tstate=%b ctl=%b",
                 i + 1, bus.tstate, ctl, ts, exp_add[i]);
      end
      step();
    end
    bus.opcode = 4'h2;
    for (int i = 0; i < 6; i++) begin
      ts = 6'b000001 << i;
      checks++;
      if (bus.tstate !== ts || ctl !== exp_sub[i]) begin
        errors++;
        $display("FAIL sub T%0d: tstate=%b ctl=%b, required tstate=%b ctl=%b",
                 i + 1, bus.tstate, ctl, ts, exp_sub[i]);
      end
      step();
    end
  endtask

  task automatic test_out_hlt();
    logic [12:0] exp_out [6];
    logic [12:0] exp_hlt [4];
    logic [5:0]  ts;
    exp_out = '{CT1, CT2, CT3, COutT4, CInact, CInact};
    exp_hlt = '{CT1, CT2, CT3, CHalt};
    bus.opcode = 4'hE;
    for (int i = 0; i < 6; i++) begin
      ts = 6'b000001 << i;
      checks++;
      if (bus.tstate !== ts || ctl !== exp_out[i]) begin
        errors++;
        $display("FAIL out T%0d: tstate=%b ctl=%b, required tstate=%b ctl=%b",
                 i + 1, bus.tstate, ctl, ts, exp_out[i]);
      end
      step();
    end
    bus.opcode = 4'hF;
    for (int i = 0; i < 4; i++) begin
      ts = 6'b000001 << i;
      checks++;
      if (bus.tstate !== ts || ctl !== exp_hlt[i]) begin
        errors++;
        $display("FAIL hlt T%0d: tstate=%b ctl=%b, required tstate=%b ctl=%b",
                 i + 1, bus.tstate, ctl, ts, exp_hlt[i]);
      end
      step();
    end
    for (int i = 0; i < 10; i++) begin
      // Opcode no longer matters once halted.
      bus.opcode = 4'(i);
      #1;
      checks++;
      if (bus.tstate !== 6'b001000 || ctl !== CHalt) begin
        errors++;
        $display("FAIL halted cycle %0d: tstate=%b ctl=%b, required tstate=001000 ctl=%b",
                 i, bus.tstate, ctl, CHalt);
      end
      step();
    end
    // Asynchronous reset out of HALTED, mid-cycle.
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.tstate !== 6'b000001 || ctl !== CInact) begin
      errors++;
      $display("FAIL reset_halted: tstate=%b ctl=%b, required tstate=000001 ctl=%b",
               bus.tstate, ctl, CInact);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset_mid();
    bus.opcode = 4'h1;
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (bus.tstate !== 6'b010000 || ctl !== CAluT5) begin
      errors++;
      $display("FAIL mid_pre T5: tstate=%b ctl=%b, required tstate=010000 ctl=%b",
               bus.tstate, ctl, CAluT5);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.tstate !== 6'b000001 || ctl !== CInact) begin
      errors++;
      $display("FAIL reset_mid: tstate=%b ctl=%b, required tstate=000001 ctl=%b",
               bus.tstate, ctl, CInact);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (bus.tstate !== 6'b000001 || ctl !== CT1) begin
      errors++;
      $display("FAIL reset_mid_release: tstate=%b ctl=%b, required tstate=000001 ctl=%b",
               bus.tstate, ctl, CT1);
    end
    step();
    checks++;
    if (bus.tstate !== 6'b000010 || ctl !== CT2) begin
      errors++;
      $display("FAIL reset_mid_T2: tstate=%b ctl=%b, required tstate=000010 ctl=%b",
               bus.tstate, ctl, CT2);
    end
    for (int i = 0; i < 5; i++) step();
  endtask

  task automatic test_undef_glitch();
    logic [12:0] exp_nop [6];
    logic [12:0] exp_f [3];
    logic [5:0]  ts;
    exp_nop = '{CT1, CT2, CT3, CInact, CInact, CInact};
    exp_f   = '{CT1, CT2, CT3};
    bus.opcode = 4'h7;
    for (int i = 0; i < 6; i++) begin
      ts = 6'b000001 << i;
      checks++;
      if (bus.tstate !== ts || ctl !== exp_nop[i]) begin
        errors++;
        $display("FAIL undef T%0d: tstate=%b ctl=%b, required tstate=%b ctl=%b",
                 i + 1, bus.tstate, ctl, ts, exp_nop[i]);
      end
      step();
    end
    for (int i = 0; i < 3; i++) begin
      ts = 6'b000001 << i;
      bus.opcode = 4'h0;
      #1;
      checks++;
      if (bus.tstate !== ts || ctl !== exp_f[i]) begin
        errors++;
        $display("FAIL glitch0 T%0d: tstate=%b ctl=%b, required tstate=%b ctl=%b",
                 i + 1, bus.tstate, ctl, ts, exp_f[i]);
      end
      bus.opcode = 4'hF;
      #1;
      checks++;
      if (bus.tstate !== ts || ctl !== exp_f[i]) begin
        errors++;
        $display("FAIL glitchF T%0d: tstate=%b ctl=%b, required tstate=%b ctl=%b",
                 i + 1, bus.tstate, ctl, ts, exp_f[i]);
      end
      if (i == 2) bus.opcode = 4'h0;
      step();
    end
    checks++;
    if (bus.tstate !== 6'b001000 || ctl !== CMemT4) begin
      errors++;
      $display("FAIL glitch_T4: tstate=%b ctl=%b, required tstate=001000 ctl=%b",
               bus.tstate, ctl, CMemT4);
    end
    step();
    step();
    step();
  endtask

  task automatic test_random_stream();
    logic [3:0] ops [14];
    logic [4:0] drv;
    logic [5:0] ts;
    ops = '{4'h0, 4'h1, 4'h2, 4'hE, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA,
            4'hB, 4'hC};
    for (int n = 0; n < 1000; n++) begin
      bus.opcode = ops[$urandom_range(13, 0)];
      for (int i = 0; i < 6; i++) begin
        ts  = 6'b000001 << i;
        drv = {bus.ep, ~bus.ce_n, ~bus.ei_n, bus.ea, bus.eu};
        checks++;
        if (!$onehot0(drv) || bus.tstate !== ts) begin
          errors++;
          $display("FAIL stream instr %0d T%0d: drivers=%b tstate=%b, required <=1 driver, tstate=%b",
                   n, i + 1, drv, bus.tstate, ts);
        end
        step();
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.opcode = 4'h0;
    test_reset();
    test_add_sub();
    test_out_hlt();
    test_reset_mid();
    test_undef_glitch();
    test_random_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
